router_input_fifo: RTL and testbench

ROUTER_INPUT_FIFO -- requirements
Module: router_input_fifo

---
 rtl/router_input_fifo_if.sv | 59 +++++
 rtl/router_input_fifo.sv | 148 ++++++++++++++
 tb/tb_router_input_fifo.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/router_input_fifo_if.sv
// router_input_fifo_if
// Handshake and bus bundle between an upstream link, the router input FIFO,
// and the routing stage that drains it.
//
// Signals:
//   rx_valid  - upstream writes rx_flit this cycle
//   rx_flit   - incoming flit (FLIT_W bits)
//   rd_en     - downstream pops the head flit this cycle
//   empty     - no flit stored
//   full      - DEPTH flits stored
//   flit_out  - head flit (first-word-fall-through)
//   flit_type - flit_out[FLIT_W-1:FLIT_W-3]
//   dst_addr  - flit_out[`AXIS-1:0]
//   flow_out  - upstream flow control (ready level or credit pulse)
//   err       - sticky protocol/overflow error
//
// Modports: master = upstream/downstream side driving rx_* and rd_en,
//           slave  = the FIFO itself.
//
// Flit-format macros `AXIS, `HEADER, `BODY and `TAIL get defaults here when
// the surrounding project does not supply them.

`ifndef AXIS
`define AXIS 4
`endif
`ifndef HEADER
`define HEADER 3'b001
`endif
`ifndef BODY
`define BODY 3'b010
`endif
`ifndef TAIL
`define TAIL 3'b011
`endif

interface router_input_fifo_if #(
    parameter int FLIT_W = 32
);
    logic              rx_valid;
    logic [FLIT_W-1:0] rx_flit;
    logic              rd_en;
    logic              empty;
    logic              full;
    logic [FLIT_W-1:0] flit_out;
    logic [2:0]        flit_type;
    logic [`AXIS-1:0]  dst_addr;
    logic              flow_out;
    logic              err;

    modport master (
        output rx_valid, rx_flit, rd_en,
        input  empty, full, flit_out, flit_type, dst_addr, flow_out, err
    );

    modport slave (
        input  rx_valid, rx_flit, rd_en,
        output empty, full, flit_out, flit_type, dst_addr, flow_out, err
    );
endinterface

// File: rtl/router_input_fifo.sv
// router_input_fifo
// Input buffer for one router port: a DEPTH-deep first-word-fall-through
// FIFO of FLIT_W-bit flits with a packet-framing checker and a sticky error.
//
// Ports:
//   clk  - single clock, all state updates on the rising edge
//   rst  - synchronous active-high reset
//   bus  - router_input_fifo_if.slave (rx_valid/rx_flit/rd_en in;
//          empty/full/flit_out/flit_type/dst_addr/flow_out/err out)
//
// Parameters: FLIT_W (flit width), DEPTH (slots, power of two, >= 2).
//
// Build option ROUTER_FIFO_CREDIT_EN:
//   defined   -> flow_out is a one-cycle credit pulse, registered one cycle
//                after each accepted read (upstream starts with DEPTH credits)
//   undefined -> flow_out = ~full (combinational ready)

`ifndef AXIS
`define AXIS 4
`endif
`ifndef HEADER
`define HEADER 3'b001
`endif
`ifndef TAIL
`define TAIL 3'b011
`endif

module router_input_fifo #(
    parameter int FLIT_W = 32,
    parameter int DEPTH  = 4
) (
    input logic                clk,
    input logic                rst,
    router_input_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

    typedef enum logic {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } pkt_state_t;

    logic [FLIT_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr_reg;
    logic [AW-1:0]     rd_ptr_reg;
    logic [AW:0]       count_reg;
    logic [AW:0]       count_next;
    logic              err_reg;
    pkt_state_t        state_reg;
    pkt_state_t        state_next;

    logic       rd_acc;
    logic       wr_acc;
    logic       overflow;
    logic       pkt_err;
    logic [2:0] rx_type;

    assign bus.empty = (count_reg == '0);
    assign bus.full  = (count_reg == DEPTH_CNT);

    // A full FIFO still takes a write when the same cycle frees a slot.
    assign rd_acc   = bus.rd_en & ~bus.empty;
    assign wr_acc   = bus.rx_valid & (~bus.full | rd_acc);
    assign overflow = bus.rx_valid & ~wr_acc;
    assign rx_type  = bus.rx_flit[FLIT_W-1:FLIT_W-3];

    // Data array: no reset, stored contents survive rst by design.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc) begin
            mem[wr_ptr_reg] <= bus.rx_flit;
        end
    end

    always_comb begin
        count_next = count_reg;
        case ({wr_acc, rd_acc})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            err_reg    <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (rd_acc) rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_next;
            err_reg   <= err_reg | overflow | pkt_err;
        end
    end

    // Packet checker: state register
    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    // Packet checker: next state (only accepted writes advance it)
    always_comb begin
        state_next = state_reg;
        if (wr_acc) begin
            case (state_reg)
                IDLE:    if (rx_type == `HEADER) state_next = IN_PKT;
                IN_PKT:  if (rx_type == `TAIL)   state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Packet checker: outputs. A HEADER inside a packet is flagged but
    // treated as the start of a new packet, so the state stays IN_PKT.
    always_comb begin
        pkt_err = 1'b0;
        if (wr_acc) begin
            case (state_reg)
                IDLE:    pkt_err = (rx_type != `HEADER);
                IN_PKT:  pkt_err = (rx_type == `HEADER);
                default: pkt_err = 1'b0;
            endcase
        end
    end

    assign bus.flit_out  = mem[rd_ptr_reg];
    assign bus.flit_type = bus.flit_out[FLIT_W-1:FLIT_W-3];
    assign bus.dst_addr  = bus.flit_out[`AXIS-1:0];
    assign bus.err       = err_reg;

`ifdef ROUTER_FIFO_CREDIT_EN
    logic credit_reg;

    // Each freed slot returns one credit the cycle after the read.
    always_ff @(posedge clk) begin
        if (rst) credit_reg <= 1'b0;
        else     credit_reg <= rd_acc;
    end

    assign bus.flow_out = credit_reg;
`else
    assign bus.flow_out = ~bus.full;
`endif

endmodule

// File: tb/tb_router_input_fifo.sv
`ifndef AXIS
`define AXIS 4
`endif
`ifndef HEADER
`define HEADER 3'b001
`endif
`ifndef BODY
`define BODY 3'b010
`endif
`ifndef TAIL
`define TAIL 3'b011
`endif

module tb_router_input_fifo;
    localparam int FLIT_W = 32;
    localparam int DEPTH  = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    router_input_fifo_if #(.FLIT_W(FLIT_W)) bus ();

    router_input_fifo #(.FLIT_W(FLIT_W), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: queue of stored flits plus packet/error bookkeeping.
    logic [FLIT_W-1:0] q[$];
    bit m_err;
    bit m_in_pkt;
    bit m_flow;

    function automatic logic [FLIT_W-1:0] mk(input logic [2:0] t, input logic [3:0] d);
        logic [24:0] mid;
        mid = 25'($urandom);
        return {t, mid, d};
    endfunction

    function automatic bit credit_build();
`ifdef ROUTER_FIFO_CREDIT_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        bus.rx_valid = 1'b1;
        bus.rx_flit  = mk(`BODY, 4'hF);
        bus.rd_en    = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rd_en    = 1'b0;
        q.delete();
        m_err    = 1'b0;
        m_in_pkt = 1'b0;
        m_flow   = !credit_build();
    endtask

    // One clock of stimulus; the model advances from the pre-edge queue.
    task automatic step(input bit v, input logic [FLIT_W-1:0] f, input bit r);
        bit pop, acc;
        logic [2:0] t;
        bus.rx_valid = v;
        bus.rx_flit  = f;
        bus.rd_en    = r;
        pop = r && (q.size() > 0);
        acc = v && ((q.size() < DEPTH) || pop);
        @(posedge clk); #1;
        if (pop) q.delete(0);
        if (acc) begin
            q.push_back(f);
            t = f[FLIT_W-1:FLIT_W-3];
            if (!m_in_pkt) begin
                if (t == `HEADER) m_in_pkt = 1'b1;
                else              m_err = 1'b1;
            end else if (t == `TAIL) begin
                m_in_pkt = 1'b0;
            end else if (t == `HEADER) begin
                m_err = 1'b1;
            end
        end
        if (v && !acc) m_err = 1'b1;
        m_flow = credit_build() ? pop : (q.size() != DEPTH);
        bus.rx_valid = 1'b0;
        bus.rd_en    = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", bus.empty); end
        checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", bus.full); end
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", bus.err); end
        checks++; if (bus.flow_out !== m_flow) begin errors++; $display("FAIL reset_flow got=%b exp=%b", bus.flow_out, m_flow); end
        $display("test_reset done");
    endtask

    task automatic test_packet();
        do_reset();
        step(1, mk(`HEADER, 4'h1), 0);
        step(1, mk(`BODY,   4'h5), 0);
        step(1, mk(`TAIL,   4'h7), 0);
        checks++; if (bus.empty !== 1'b0) begin errors++; $display("FAIL pkt_empty got=%b exp=0", bus.empty); end
        checks++; if (bus.flit_type !== `HEADER) begin errors++; $display("FAIL pkt_type got=%h exp=%h", bus.flit_type, `HEADER); end
        checks++; if (bus.dst_addr !== 4'h1) begin errors++; $display("FAIL pkt_dst got=%h exp=1", bus.dst_addr); end
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL pkt_err got=%b exp=0", bus.err); end
        // Drain: exactly three flits must come out in order.
        for (int i = 0; i < 3; i++) begin
            checks++; if (bus.empty !== 1'b0 || bus.flit_out !== q[0]) begin
                errors++; $display("FAIL pkt_drain%0d got=%h exp=%h empty=%b", i, bus.flit_out, q[0], bus.empty);
            end
            step(0, '0, 1);
        end
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL pkt_count3 got_empty=%b exp=1", bus.empty); end
        $display("test_packet done");
    endtask

    task automatic test_overflow();
        logic [FLIT_W-1:0] head;
        do_reset();
        step(1, mk(`HEADER, 4'h2), 0);
        for (int i = 0; i < 3; i++) step(1, mk(`BODY, 4'(i)), 0);
        head = q[0];
        checks++; if (bus.full !== 1'b1 || bus.err !== 1'b0) begin errors++; $display("FAIL ovf_fill full=%b err=%b exp full=1 err=0", bus.full, bus.err); end
        checks++; if (bus.flow_out !== m_flow) begin errors++; $display("FAIL ovf_flow got=%b exp=%b", bus.flow_out, m_flow); end
        step(1, mk(`BODY, 4'hA), 0);
        checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL ovf_err got=%b exp=1", bus.err); end
        checks++; if (bus.full !== 1'b1 || bus.flit_out !== head) begin errors++; $display("FAIL ovf_head got=%h exp=%h full=%b", bus.flit_out, head, bus.full); end
        // Sticky: error survives further clean traffic.
        step(0, '0, 1);
        checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b exp=1", bus.err); end
        $display("test_overflow done");
    endtask

    task automatic test_full_rw();
        do_reset();
        step(1, mk(`HEADER, 4'h3), 0);
        for (int i = 0; i < 3; i++) step(1, mk(`BODY, 4'(i+4)), 0);
        step(1, mk(`BODY, 4'hC), 1);
        checks++; if (bus.full !== 1'b1 || bus.err !== 1'b0) begin errors++; $display("FAIL fullrw got full=%b err=%b exp full=1 err=0", bus.full, bus.err); end
        for (int i = 0; i < DEPTH; i++) begin
            checks++; if (bus.empty !== 1'b0 || bus.flit_out !== q[0]) begin
                errors++; $display("FAIL fullrw_drain%0d got=%h exp=%h", i, bus.flit_out, q[0]);
            end
            step(0, '0, 1);
        end
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL fullrw_empty got=%b exp=1", bus.empty); end
        $display("test_full_rw done");
    endtask

    task automatic test_wrap();
        int sent = 0;
        int got = 0;
        logic [FLIT_W-1:0] exp_list[$];
        logic [FLIT_W-1:0] f;
        do_reset();
        while (got < 10 && sent + got < 200) begin
            bit v, r;
            v = (sent < 10) && ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 2) != 0);
            if (q.size() == DEPTH) r = 1'b1;
            f = mk(sent == 0 ? `HEADER : (sent == 9 ? `TAIL : `BODY), 4'($urandom));
            if (r && q.size() > 0) begin
                checks++; if (bus.flit_out !== exp_list[got]) begin
                    errors++; $display("FAIL wrap_order%0d got=%h exp=%h", got, bus.flit_out, exp_list[got]);
                end
                got++;
            end
            if (v) begin exp_list.push_back(f); sent++; end
            step(v, f, r);
        end
        checks++; if (got != 10 || bus.err !== 1'b0 || bus.empty !== 1'b1) begin
            errors++; $display("FAIL wrap_total got=%0d exp=10 err=%b empty=%b", got, bus.err, bus.empty);
        end
        $display("test_wrap done");
    endtask

    task automatic test_protocol();
        do_reset();
        step(1, mk(`BODY, 4'h1), 0);
        checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL proto_body_first got=%b exp=1", bus.err); end
        checks++; if (bus.empty !== 1'b0) begin errors++; $display("FAIL proto_stored got_empty=%b exp=0", bus.empty); end
        do_reset();
        step(1, mk(`HEADER, 4'h1), 0);
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL proto_hdr got=%b exp=0", bus.err); end
        step(1, mk(`HEADER, 4'h2), 0);
        checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL proto_hdr_hdr got=%b exp=1", bus.err); end
        do_reset();
        step(1, mk(`HEADER, 4'h1), 0);
        step(1, mk(`TAIL, 4'h1), 0);
        step(1, mk(`HEADER, 4'h2), 0);
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL proto_two_pkts got=%b exp=0", bus.err); end
        $display("test_protocol done");
    endtask

    task automatic test_credit();
        int pulses = 0;
        do_reset();
        step(1, mk(`HEADER, 4'h1), 0);
        step(1, mk(`BODY, 4'h1), 0);
        step(1, mk(`TAIL, 4'h1), 0);
        for (int i = 0; i < 3; i++) begin
            step(0, '0, 1);
            checks++; if (bus.flow_out !== m_flow) begin errors++; $display("FAIL credit_rd%0d got=%b exp=%b", i, bus.flow_out, m_flow); end
            if (bus.flow_out === 1'b1 && credit_build()) pulses++;
            step(0, '0, 0);
            checks++; if (bus.flow_out !== m_flow) begin errors++; $display("FAIL credit_idle%0d got=%b exp=%b", i, bus.flow_out, m_flow); end
            if (bus.flow_out === 1'b1 && credit_build()) pulses++;
        end
`ifdef ROUTER_FIFO_CREDIT_EN
        checks++; if (pulses != 3) begin errors++; $display("FAIL credit_pulses got=%0d exp=3", pulses); end
`endif
        $display("test_credit done pulses=%0d", pulses);
    endtask

    task automatic test_reset_midpkt();
        do_reset();
        step(1, mk(`HEADER, 4'h6), 0);
        step(1, mk(`BODY, 4'h6), 0);
        do_reset();
        checks++; if (bus.empty !== 1'b1 || bus.full !== 1'b0 || bus.err !== 1'b0) begin
            errors++; $display("FAIL midrst got empty=%b full=%b err=%b exp 1/0/0", bus.empty, bus.full, bus.err);
        end
        // FSM back in IDLE: a BODY now is a framing error.
        step(1, mk(`BODY, 4'h6), 0);
        checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL midrst_fsm got=%b exp=1", bus.err); end
        $display("test_reset_midpkt done");
    endtask

    task automatic test_random();
        logic [2:0] types [3];
        types[0] = `HEADER; types[1] = `BODY; types[2] = `TAIL;
        do_reset();
        for (int i = 0; i < 300; i++) begin
            if (i == 150) do_reset();
            step($urandom_range(0, 1), mk(types[$urandom_range(0, 2)], 4'($urandom)), $urandom_range(0, 1));
            checks++; if (bus.empty !== (q.size() == 0) || bus.full !== (q.size() == DEPTH)) begin
                errors++; $display("FAIL rnd_flags cyc=%0d got e=%b f=%b exp size=%0d", i, bus.empty, bus.full, q.size());
            end
            if (q.size() > 0) begin
                checks++; if (bus.flit_out !== q[0] || bus.flit_type !== q[0][31:29] || bus.dst_addr !== q[0][3:0]) begin
                    errors++; $display("FAIL rnd_head cyc=%0d got=%h exp=%h", i, bus.flit_out, q[0]);
                end
            end
            checks++; if (bus.err !== m_err || bus.flow_out !== m_flow) begin
                errors++; $display("FAIL rnd_err_flow cyc=%0d got err=%b flow=%b exp err=%b flow=%b", i, bus.err, bus.flow_out, m_err, m_flow);
            end
        end
        $display("test_random done");
    endtask

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_flit  = '0;
        bus.rd_en    = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_packet();
        test_overflow();
        test_full_rw();
        test_wrap();
        test_protocol();
        test_credit();
        test_reset_midpkt();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end
endmodule
